// File: rtl/wb_pkg.sv
// Shared types and constants for the MEM/WB write-back slice.
package wb_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 4;
  localparam int NUM_REGS = 2 ** REG_AW;

  typedef struct packed {
    logic              valid;
    logic              RegWrite;
    logic              MemToReg;
    logic [REG_AW-1:0] DstReg;
    logic [DATA_W-1:0] ALUResult;
    logic [DATA_W-1:0] MemData;
    logic              Halt;
  } wb_entry_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_dst_decoder.sv
// Address to one-hot decoder with enable; used for register write enables
// and register-file read selects.
module wb_dst_decoder
  import wb_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic              en,
  input  logic [AW-1:0]     sel,
  output logic [2**AW-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, write-data select, one-hot write-enable decode
// and processor halt state. Optional write counter under WB_PERF_CNT_EN.
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic                 in_RegWrite,
  input  logic                 in_MemToReg,
  input  logic [REG_AW-1:0]    in_DstReg,
  input  logic [DATA_W-1:0]    in_ALUResult,
  input  logic [DATA_W-1:0]    in_MemData,
  input  logic                 in_Halt,
  output logic [2**REG_AW-1:0] WriteEnable,
  output logic [DATA_W-1:0]    DstData,
  output logic                 wb_valid,
  output logic                 wb_RegWrite,
  output logic [REG_AW-1:0]    wb_DstReg,
  output logic                 halted
`ifdef WB_PERF_CNT_EN
  ,
  output logic [15:0]          wb_count
`endif
);

  import wb_pkg::*;

  // Entry layout follows the package widths; parameters must match them.
  wb_entry_t entry;
  wb_entry_t load_e;
  logic      committed;
  wb_state_t state_q, state_d;
  logic      we_en;

  always_comb begin
    load_e           = '0;
    load_e.valid     = in_valid;
    load_e.RegWrite  = in_RegWrite;
    load_e.MemToReg  = in_MemToReg;
    load_e.DstReg    = in_DstReg;
    load_e.ALUResult = in_ALUResult;
    load_e.MemData   = in_MemData;
    load_e.Halt      = in_Halt;
  end

  // committed marks an entry that already had its write cycle, so a stalled
  // entry never writes the register file twice.
  always_ff @(posedge clk) begin
    if (!rst) begin
      entry     <= '0;
      committed <= 1'b0;
    end else if (state_q == RUN) begin
      if (flush) begin
        entry.valid <= 1'b0;
        committed   <= 1'b0;
      end else if (stall) begin
        if (entry.valid) committed <= 1'b1;
      end else begin
        entry     <= load_e;
        committed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (entry.valid && entry.Halt) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    halted = (state_q == HALTED);
    we_en  = (state_q == RUN) && entry.valid && entry.RegWrite && !entry.Halt
             && !committed && (entry.DstReg != '0);
  end

  wb_dst_decoder #(
    .AW(REG_AW)
  ) u_dst_dec (
    .en     (we_en),
    .sel    (entry.DstReg),
    .onehot (WriteEnable)
  );

  assign DstData     = entry.MemToReg ? entry.MemData : entry.ALUResult;
  assign wb_valid    = entry.valid;
  assign wb_RegWrite = entry.RegWrite;
  assign wb_DstReg   = entry.DstReg;

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) wb_count <= '0;
    else if (state_q == RUN && WriteEnable != '0 && wb_count != '1)
      wb_count <= wb_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// traffic compared against an instruction-level reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        in_valid, in_RegWrite, in_MemToReg, in_Halt;
  logic [3:0]  in_DstReg;
  logic [15:0] in_ALUResult, in_MemData;
  logic [15:0] WriteEnable, DstData;
  logic        wb_valid, wb_RegWrite, halted;
  logic [3:0]  wb_DstReg;
`ifdef WB_PERF_CNT_EN
  logic [15:0] wb_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(16), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_RegWrite(in_RegWrite), .in_MemToReg(in_MemToReg),
    .in_DstReg(in_DstReg), .in_ALUResult(in_ALUResult), .in_MemData(in_MemData),
    .in_Halt(in_Halt), .WriteEnable(WriteEnable), .DstData(DstData),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_DstReg(wb_DstReg),
    .halted(halted)
`ifdef WB_PERF_CNT_EN
    , .wb_count(wb_count)
`endif
  );

  // Reference model: the instruction sitting in WB, whether it has already
  // had its write cycle, the halt flag and the count of writes performed.
  logic        m_valid, m_rw, m_m2r, m_hlt, m_done, m_halted;
  logic [3:0]  m_dst;
  logic [15:0] m_alu, m_md;
  int          m_count;

  function automatic logic [15:0] exp_we();
    if (m_valid && m_rw && !m_hlt && !m_done && m_dst != 4'd0 && !m_halted)
      return 16'(1 << m_dst);
    return 16'h0000;
  endfunction

  function automatic logic [15:0] exp_data();
    return m_m2r ? m_md : m_alu;
  endfunction

  task automatic tick();
    logic go_halt;
    @(posedge clk);
    if (!rst) begin
      {m_valid, m_rw, m_m2r, m_hlt, m_done, m_halted} = '0;
      m_dst = '0; m_alu = '0; m_md = '0; m_count = 0;
    end else if (!m_halted) begin
      if (exp_we() != 16'h0000 && m_count < 65535) m_count++;
      go_halt = m_valid && m_hlt;
      if (flush) begin
        m_valid = 1'b0; m_done = 1'b0;
      end else if (stall) begin
        if (m_valid) m_done = 1'b1;
      end else begin
        m_valid = in_valid; m_rw = in_RegWrite; m_m2r = in_MemToReg;
        m_dst = in_DstReg; m_alu = in_ALUResult; m_md = in_MemData;
        m_hlt = in_Halt; m_done = 1'b0;
      end
      m_halted = go_halt;
    end
    #1;
  endtask

  task automatic set_in(input logic v, input logic rw, input logic m2r,
                        input logic [3:0] dst, input logic [15:0] alu,
                        input logic [15:0] md, input logic hlt);
    in_valid = v; in_RegWrite = rw; in_MemToReg = m2r; in_DstReg = dst;
    in_ALUResult = alu; in_MemData = md; in_Halt = hlt;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 4'd9, 16'hAAAA, 16'h5555, 1'b0);
    tick();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
    checks++; if (WriteEnable !== 16'h0000) begin failures++; $display("FAIL reset_we got=%h exp=0000", WriteEnable); end
    checks++; if (DstData !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", DstData); end
    checks++; if ({wb_valid, wb_RegWrite, wb_DstReg} !== 6'b0) begin failures++; $display("FAIL reset_fwd got=%b exp=000000", {wb_valid, wb_RegWrite, wb_DstReg}); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
  endtask

  task automatic test_alu_write();
    set_in(1'b1, 1'b1, 1'b0, 4'd3, 16'h1234, 16'hDEAD, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
    checks++; if (WriteEnable !== 16'h0008) begin failures++; $display("FAIL alu_we got=%h exp=0008", WriteEnable); end
    checks++; if (DstData !== 16'h1234) begin failures++; $display("FAIL alu_data got=%h exp=1234", DstData); end
    tick();
  endtask

  task automatic test_stall_once();
    set_in(1'b1, 1'b1, 1'b1, 4'd15, 16'h0101, 16'hBEEF, 1'b0);
    tick();
    checks++; if (WriteEnable !== 16'h8000) begin failures++; $display("FAIL stall_first_we got=%h exp=8000", WriteEnable); end
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL stall_first_valid got=%b exp=1", wb_valid); end
    stall = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 4'd2, 16'h7777, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (WriteEnable !== 16'h0000) begin failures++; $display("FAIL stall_hold_we[%0d] got=%h exp=0000", i, WriteEnable); end
      checks++; if (wb_valid !== 1'b1 || DstData !== 16'hBEEF) begin failures++; $display("FAIL stall_hold_entry[%0d] got=%b/%h exp=1/beef", i, wb_valid, DstData); end
    end
    stall = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
    tick();
  endtask

  task automatic test_r0_and_flush();
    set_in(1'b1, 1'b1, 1'b0, 4'd0, 16'h4321, 16'h0, 1'b0);
    tick();
    checks++; if (WriteEnable !== 16'h0000) begin failures++; $display("FAIL r0_we got=%h exp=0000", WriteEnable); end
    checks++; if (DstData !== 16'h4321) begin failures++; $display("FAIL r0_data got=%h exp=4321", DstData); end
    flush = 1'b1; stall = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 4'd6, 16'h6666, 16'h0, 1'b0);
    tick();
    flush = 1'b0; stall = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", wb_valid); end
    checks++; if (WriteEnable !== 16'h0000) begin failures++; $display("FAIL flush_we got=%h exp=0000", WriteEnable); end
  endtask

  task automatic test_halt();
    set_in(1'b1, 1'b1, 1'b0, 4'd7, 16'h0700, 16'h0, 1'b1);
    tick();
    checks++; if (WriteEnable !== 16'h0000 || halted !== 1'b0) begin failures++; $display("FAIL hlt_entry got=%h/%b exp=0000/0", WriteEnable, halted); end
    set_in(1'b1, 1'b1, 1'b0, 4'd2, 16'h0200, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (halted !== 1'b1 || WriteEnable !== 16'h0000) begin failures++; $display("FAIL halted_hold[%0d] got=%b/%h exp=1/0000", i, halted, WriteEnable); end
      in_DstReg = 4'(i + 8);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (halted !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL halt_reset got=%b/%b exp=0/0", halted, wb_valid); end
    set_in(1'b1, 1'b1, 1'b0, 4'd5, 16'h5050, 16'h0, 1'b0);
    tick();
    checks++; if (WriteEnable !== 16'h0020) begin failures++; $display("FAIL halt_rerun_we got=%h exp=0020", WriteEnable); end
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 99) >= 3);
      flush = ($urandom_range(0, 99) < 10);
      stall = ($urandom_range(0, 99) < 25);
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
             16'($urandom), 16'($urandom), $urandom_range(0, 99) < 3);
      tick();
      checks++; if (WriteEnable !== exp_we()) begin failures++; $display("FAIL rnd_we[%0d] got=%h exp=%h", n, WriteEnable, exp_we()); end
      checks++; if (DstData !== exp_data()) begin failures++; $display("FAIL rnd_data[%0d] got=%h exp=%h", n, DstData, exp_data()); end
      checks++; if ({wb_valid, wb_RegWrite, wb_DstReg} !== {m_valid, m_rw, m_dst}) begin failures++; $display("FAIL rnd_fwd[%0d] got=%b exp=%b", n, {wb_valid, wb_RegWrite, wb_DstReg}, {m_valid, m_rw, m_dst}); end
      checks++; if (halted !== m_halted) begin failures++; $display("FAIL rnd_halted[%0d] got=%b exp=%b", n, halted, m_halted); end
`ifdef WB_PERF_CNT_EN
      checks++; if (wb_count !== 16'(m_count)) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, wb_count, m_count); end
`endif
    end
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
  endtask

`ifdef WB_PERF_CNT_EN
  task automatic test_perf_count();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
    tick();
    rst = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 4'd1, 16'h0001, 16'h0, 1'b0); tick();
    set_in(1'b1, 1'b1, 1'b0, 4'd0, 16'h0002, 16'h0, 1'b0); tick();
    set_in(1'b1, 1'b1, 1'b0, 4'd2, 16'h0003, 16'h0, 1'b0); tick();
    stall = 1'b1; tick(); tick(); stall = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 4'd3, 16'h0004, 16'h0, 1'b0); tick();
    set_in(1'b1, 1'b1, 1'b0, 4'd4, 16'h0005, 16'h0, 1'b0); tick();
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0); tick();
    checks++; if (wb_count !== 16'd4) begin failures++; $display("FAIL perf_count got=%0d exp=4", wb_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_write();
    test_stall_once();
    test_r0_and_flush();
    test_halt();
    test_random();
`ifdef WB_PERF_CNT_EN
    test_perf_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and write-back control for the 16-entry register file. Captures the memory-stage result and selects the write data (ALU result or load data). Decodes the destination register into the one-hot per-register write enables that drive every bit cell's `WriteEnable`. Also owns the processor halt state and guarantees each instruction writes the register file exactly once, even under stalls.

## Interface
Parameters:
- `DATA_W`, 16, datapath width
- `REG_AW`, 4, register address width; register count = 2**REG_AW

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset
- `stall`  in  1  hold the current entry; do not load new input
- `flush`  in  1  load a bubble instead of the input
- `in_valid`  in  1  MEM stage holds a real instruction
- `in_RegWrite`  in  1  instruction writes a register
- `in_MemToReg`  in  1  1: write `in_MemData`; 0: write `in_ALUResult`
- `in_DstReg`  in  REG_AW  destination register
- `in_ALUResult`  in  DATA_W  ALU/PC result
- `in_MemData`  in  DATA_W  load data
- `in_Halt`  in  1  instruction is HLT
- `WriteEnable`  out  2**REG_AW  one-hot register write enables
- `DstData`  out  DATA_W  write data to all registers
- `wb_valid`  out  1  WB entry valid (forwarding)
- `wb_RegWrite`  out  1  WB entry writes a register (forwarding)
- `wb_DstReg`  out  REG_AW  WB destination (forwarding)
- `halted`  out  1  processor halted

## Operation
- Entry register holds `valid, RegWrite, MemToReg, DstReg, ALUResult, MemData, Halt` plus a `committed` flag.
- Update priority: reset > HALTED state > flush > stall > load.
  - reset: clears all fields, `committed`=0, state=RUN.
  - HALTED: entry and flag frozen.
  - flush: clears `valid` (bubble), `committed`=0.
  - stall: entry held; `committed` is set to 1 if the entry was valid this cycle.
  - load: captures all inputs, `committed`=0.
- `DstData` = `MemToReg ? MemData : ALUResult`. It is driven even for bubbles; consumers qualify it with `WriteEnable`.
- `WriteEnable` = `1 << DstReg` when `valid & RegWrite & !Halt & !committed & DstReg != 0 & state == RUN`; otherwise all zero.
  - Register 0 is never written.
  - At most one bit is set.
- FSM states RUN and HALTED.
  - RUN → HALTED on the rising edge where the registered entry has `valid & Halt`. A HLT entry never writes.
  - HALTED is exited only by reset.
- `wb_valid`, `wb_RegWrite`, `wb_DstReg` mirror the entry fields directly (not gated by `committed`) so forwarding still works during stalls.
- Reset values: `WriteEnable`=0, `DstData`=0, `wb_valid`=0, `wb_RegWrite`=0, `wb_DstReg`=0, `halted`=0.

## Timing
- Latency: 1 cycle from input capture to `WriteEnable`/`DstData`. The register file writes on the following edge.
- Outputs are combinational from registered state only; there is no input-to-output path.
- Stall held N cycles on a valid writing entry: `WriteEnable` is asserted in the first cycle only, and zero for the remaining N.
- `flush` and `stall` in the same cycle: flush wins.
- `halted` rises 1 cycle after the HLT entry is registered, and stays high until reset.
- Reset asserted mid-stall or while HALTED: next cycle is RUN with an empty entry.

## Configuration
- `WB_PERF_CNT_EN`
  - Defined: adds output `wb_count` [15:0]. It increments by 1 on each edge where `WriteEnable != 0`, saturates at 16'hFFFF, resets to 0, and is frozen in HALTED.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `wb_pkg`:
  - `DATA_W`, `REG_AW`, `NUM_REGS` constants
  - entry struct typedef
  - FSM state enum {RUN, HALTED}
- Sub-module `wb_dst_decoder`: REG_AW-to-2**REG_AW one-hot decoder with enable, shared with the register file's read-select path.

## Test plan
- Load ALU op (RegWrite=1, DstReg=3, ALUResult=16'h1234, MemToReg=0) → next cycle `WriteEnable`=16'h0008, `DstData`=16'h1234.
- Load (MemToReg=1, DstReg=15, MemData=16'hBEEF) with `stall` held 3 cycles → `WriteEnable`=16'h8000 for exactly 1 cycle, `wb_valid`=1 for all 4 cycles.
- Write with DstReg=0 → `WriteEnable`=0; a flush and stall asserted together on a valid input → bubble, `wb_valid`=0.
- HLT enters WB → `WriteEnable`=0, `halted`=1 the next cycle; later valid inputs are ignored; `rst`=0 for one cycle → `halted`=0, state RUN.
- With `WB_PERF_CNT_EN`: 5 writing instructions, 1 to R0, 1 stalled twice → `wb_count`=4.
